// File: rtl/gemini_issue_pkg.sv
// Shared definitions for the decode/issue stage: instruction class encoding and
// default multiply/divide occupancy latencies.
package gemini_issue_pkg;

  typedef enum logic [2:0] {
    ClsAlu    = 3'd0,
    ClsLoad   = 3'd1,
    ClsStore  = 3'd2,
    ClsBranch = 3'd3,
    ClsMuldiv = 3'd4,
    ClsHiloRd = 3'd5,
    ClsPriv   = 3'd6
  } insn_class_e;

  localparam int unsigned DefaultDivCycles = 32;
  localparam int unsigned DefaultMulCycles = 2;

endpackage

// File: rtl/md_busy_timer.sv
// HI/LO occupancy timer: after a start, busy stays high for exactly DIV_CYCLES or
// MUL_CYCLES cycles, then drops.
module md_busy_timer
  import gemini_issue_pkg::*;
#(
  parameter int unsigned DIV_CYCLES = DefaultDivCycles,
  parameter int unsigned MUL_CYCLES = DefaultMulCycles
) (
  input  logic clk,
  input  logic rst,
  input  logic start,
  input  logic is_div,
  output logic busy
);

  localparam int unsigned CntW = $clog2(DIV_CYCLES + 1);
  // The entry cycle counts as the first busy cycle, hence the minus one.
  localparam logic [CntW-1:0] DivLoad = CntW'(DIV_CYCLES - 1);
  localparam logic [CntW-1:0] MulLoad = CntW'(MUL_CYCLES - 1);

  typedef enum logic {StIdle, StBusy} state_e;

  state_e          state_q;
  logic [CntW-1:0] cnt_q;

  // FSM with down-counter; busy is registered alongside the state.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= StIdle;
      cnt_q   <= '0;
      busy    <= 1'b0;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (start) begin
            cnt_q   <= is_div ? DivLoad : MulLoad;
            state_q <= StBusy;
            busy    <= 1'b1;
          end
        end
        StBusy: begin
          if (cnt_q == '0) begin
            state_q <= StIdle;
            busy    <= 1'b0;
          end else begin
            cnt_q <= cnt_q - CntW'(1);
          end
        end
        default: begin
          state_q <= StIdle;
          busy    <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: rtl/issue_ctrl.sv
// Dual-issue decision for the decoded pair: blocks only on load-use and HI/LO
// occupancy, restricts the second pipe to ALU, and counts hazard stall cycles.
module issue_ctrl
  import gemini_issue_pkg::*;
#(
  parameter int unsigned DIV_CYCLES = DefaultDivCycles,
  parameter int unsigned MUL_CYCLES = DefaultMulCycles
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        flush,
  input  logic        ex_stall,
  input  logic        d0_valid,
  input  logic        d1_valid,
  input  logic [4:0]  d0_rs,
  input  logic [4:0]  d0_rt,
  input  logic [4:0]  d1_rs,
  input  logic [4:0]  d1_rt,
  input  logic        d0_rs_ren,
  input  logic        d0_rt_ren,
  input  logic        d1_rs_ren,
  input  logic        d1_rt_ren,
  input  logic        d0_wen,
  input  logic        d1_wen,
  input  logic [4:0]  d0_waddr,
  input  logic [4:0]  d1_waddr,
  input  insn_class_e d0_class,
  input  insn_class_e d1_class,
  input  logic        d0_is_div,
  input  logic        ex0_load,
  input  logic [4:0]  ex0_waddr,
  output logic        issue0,
  output logic        issue1,
  output logic        md_start,
  output logic        md_is_div,
  output logic        md_busy,
  output logic [31:0] stall_cnt
);

  logic loaduse0;
  logic loaduse1;
  logic raw10;
  logic hilo_block;
  logic stall_inc;

  // Slot-1 destination only matters for WAW, which forwarding priority resolves.
  logic unused_d1_dest;
  assign unused_d1_dest = ^{d1_wen, d1_waddr};

  // Hazard detection and issue decision; purely combinational, no added latency.
  always_comb begin
    loaduse0 = ex0_load & (ex0_waddr != 5'd0) &
               ((d0_rs_ren & (d0_rs == ex0_waddr)) | (d0_rt_ren & (d0_rt == ex0_waddr)));
    loaduse1 = ex0_load & (ex0_waddr != 5'd0) &
               ((d1_rs_ren & (d1_rs == ex0_waddr)) | (d1_rt_ren & (d1_rt == ex0_waddr)));
    raw10    = d0_wen & (d0_waddr != 5'd0) &
               ((d1_rs_ren & (d1_rs == d0_waddr)) | (d1_rt_ren & (d1_rt == d0_waddr)));
    hilo_block = md_busy & ((d0_class == ClsMuldiv) | (d0_class == ClsHiloRd));

    issue0 = d0_valid & ~flush & ~ex_stall & ~loaduse0 & ~hilo_block;
    issue1 = issue0 & d1_valid & (d1_class == ClsAlu) & ~raw10 & ~loaduse1 &
             (d0_class != ClsPriv);

    md_start  = issue0 & (d0_class == ClsMuldiv);
    md_is_div = md_start & d0_is_div;

    // ex_stall and flush cycles are not hazard stalls.
    stall_inc = d0_valid & ~flush & ~ex_stall & ~issue0;
  end

  md_busy_timer #(
    .DIV_CYCLES (DIV_CYCLES),
    .MUL_CYCLES (MUL_CYCLES)
  ) u_md_busy_timer (
    .clk    (clk),
    .rst    (rst),
    .start  (md_start),
    .is_div (d0_is_div),
    .busy   (md_busy)
  );

  // Saturating hazard-stall performance counter.
  always_ff @(posedge clk) begin
    if (rst) begin
      stall_cnt <= '0;
    end else if (stall_inc && (stall_cnt != 32'hFFFF_FFFF)) begin
      stall_cnt <= stall_cnt + 32'd1;
    end
  end

endmodule

// File: tb/tb_issue_ctrl.sv
// Directed and randomized bench for issue_ctrl against a behavioural model that
// tracks HI/LO occupancy as a remaining-cycle count.
module tb_issue_ctrl;
  import gemini_issue_pkg::*;

  localparam int unsigned DivC = 32;
  localparam int unsigned MulC = 2;

  logic        clk = 1'b0;
  logic        rst, flush, ex_stall, d0_valid, d1_valid;
  logic [4:0]  d0_rs, d0_rt, d1_rs, d1_rt, d0_waddr, d1_waddr, ex0_waddr;
  logic        d0_rs_ren, d0_rt_ren, d1_rs_ren, d1_rt_ren, d0_wen, d1_wen;
  insn_class_e d0_class, d1_class;
  logic        d0_is_div, ex0_load;
  logic        issue0, issue1, md_start, md_is_div, md_busy;
  logic [31:0] stall_cnt;

  int          tests = 0;
  int          fails = 0;
  int          md_rem;
  logic [31:0] stall_ref;

  always #5 clk = ~clk;

  issue_ctrl #(
    .DIV_CYCLES (DivC),
    .MUL_CYCLES (MulC)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .flush     (flush),
    .ex_stall  (ex_stall),
    .d0_valid  (d0_valid),
    .d1_valid  (d1_valid),
    .d0_rs     (d0_rs),
    .d0_rt     (d0_rt),
    .d1_rs     (d1_rs),
    .d1_rt     (d1_rt),
    .d0_rs_ren (d0_rs_ren),
    .d0_rt_ren (d0_rt_ren),
    .d1_rs_ren (d1_rs_ren),
    .d1_rt_ren (d1_rt_ren),
    .d0_wen    (d0_wen),
    .d1_wen    (d1_wen),
    .d0_waddr  (d0_waddr),
    .d1_waddr  (d1_waddr),
    .d0_class  (d0_class),
    .d1_class  (d1_class),
    .d0_is_div (d0_is_div),
    .ex0_load  (ex0_load),
    .ex0_waddr (ex0_waddr),
    .issue0    (issue0),
    .issue1    (issue1),
    .md_start  (md_start),
    .md_is_div (md_is_div),
    .md_busy   (md_busy),
    .stall_cnt (stall_cnt)
  );

  task automatic chk1(input string tag, input logic obs, input logic exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %b expected %b", tag, obs, exp);
    end
  endtask

  task automatic chk32(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic clear_inputs();
    rst = 1'b0; flush = 1'b0; ex_stall = 1'b0;
    d0_valid = 1'b0; d1_valid = 1'b0;
    d0_rs = '0; d0_rt = '0; d1_rs = '0; d1_rt = '0;
    d0_rs_ren = 1'b0; d0_rt_ren = 1'b0; d1_rs_ren = 1'b0; d1_rt_ren = 1'b0;
    d0_wen = 1'b0; d1_wen = 1'b0; d0_waddr = '0; d1_waddr = '0;
    d0_class = ClsAlu; d1_class = ClsAlu; d0_is_div = 1'b0;
    ex0_load = 1'b0; ex0_waddr = '0;
  endtask

  task automatic set_d0(input insn_class_e c, input logic wen, input logic [4:0] wa,
                        input logic [4:0] rs, input logic ren);
    d0_valid = 1'b1; d0_class = c; d0_wen = wen; d0_waddr = wa;
    d0_rs = rs; d0_rs_ren = ren; d0_rt_ren = 1'b0;
  endtask

  task automatic set_d1(input insn_class_e c, input logic [4:0] rs, input logic ren);
    d1_valid = 1'b1; d1_class = c; d1_rs = rs; d1_rs_ren = ren; d1_rt_ren = 1'b0;
  endtask

  // One clock: check combinational outputs against the rules, advance the model.
  task automatic step();
    logic lu0, lu1, raw, busy_m, e_i0, e_i1, e_st;
    lu0 = ex0_load && ex0_waddr != 0 &&
          ((d0_rs_ren && d0_rs == ex0_waddr) || (d0_rt_ren && d0_rt == ex0_waddr));
    lu1 = ex0_load && ex0_waddr != 0 &&
          ((d1_rs_ren && d1_rs == ex0_waddr) || (d1_rt_ren && d1_rt == ex0_waddr));
    raw = d0_wen && d0_waddr != 0 &&
          ((d1_rs_ren && d1_rs == d0_waddr) || (d1_rt_ren && d1_rt == d0_waddr));
    busy_m = (md_rem > 0);
    e_i0 = d0_valid && !flush && !ex_stall && !lu0 &&
           !(busy_m && (d0_class == ClsMuldiv || d0_class == ClsHiloRd));
    e_i1 = e_i0 && d1_valid && d1_class == ClsAlu && !raw && !lu1 && d0_class != ClsPriv;
    e_st = e_i0 && d0_class == ClsMuldiv;
    #1;
    chk1("issue0", issue0, e_i0);
    chk1("issue1", issue1, e_i1);
    chk1("md_start", md_start, e_st);
    chk1("md_is_div", md_is_div, e_st && d0_is_div);
    chk1("md_busy", md_busy, busy_m);
    @(posedge clk);
    if (rst) begin
      md_rem = 0;
      stall_ref = 0;
    end else begin
      if (md_rem > 0) md_rem--;
      if (e_st) md_rem = d0_is_div ? DivC : MulC;
      if (d0_valid && !flush && !ex_stall && !e_i0 && stall_ref != 32'hFFFF_FFFF)
        stall_ref++;
    end
    #1;
    chk32("stall_cnt", stall_cnt, stall_ref);
    chk1("md_busy_after", md_busy, md_rem > 0);
  endtask

  initial begin
    logic [31:0] s0;
    int          c;
    clear_inputs();
    rst = 1'b1; md_rem = 0; stall_ref = 0;
    @(posedge clk); #1;
    step();
    rst = 1'b0;
    chk1("rst_md_busy", md_busy, 1'b0);
    chk32("rst_stall_cnt", stall_cnt, 32'd0);
    chk1("idle_issue0", issue0, 1'b0);
    chk1("idle_md_start", md_start, 1'b0);

    // RAW between slots blocks slot 1 only.
    set_d0(ClsAlu, 1'b1, 5'd5, 5'd1, 1'b1); set_d1(ClsAlu, 5'd5, 1'b1);
    #1; chk1("raw_i0", issue0, 1'b1); chk1("raw_i1", issue1, 1'b0);
    step();
    set_d1(ClsAlu, 5'd6, 1'b1);
    #1; chk1("noraw_i1", issue1, 1'b1);
    step();
    set_d0(ClsAlu, 1'b1, 5'd0, 5'd1, 1'b1); set_d1(ClsAlu, 5'd0, 1'b1);
    #1; chk1("r0_i1", issue1, 1'b1);
    step();

    // Load-use costs one cycle.
    clear_inputs();
    ex0_load = 1'b1; ex0_waddr = 5'd8; set_d0(ClsAlu, 1'b0, 5'd0, 5'd8, 1'b1);
    #1; chk1("lu_i0", issue0, 1'b0);
    step();
    chk32("lu_cnt", stall_cnt, 32'd1);
    ex0_load = 1'b0;
    #1; chk1("lu_after_i0", issue0, 1'b1);
    step();

    // Divide occupancy: MFLO waits 32 cycles.
    clear_inputs();
    set_d0(ClsMuldiv, 1'b0, 5'd0, 5'd1, 1'b1); d0_is_div = 1'b1;
    #1; chk1("div_start", md_start, 1'b1); chk1("div_isdiv", md_is_div, 1'b1);
    step();
    s0 = stall_ref;
    set_d0(ClsHiloRd, 1'b1, 5'd3, 5'd0, 1'b0); d0_is_div = 1'b0;
    for (int i = 0; i < 32; i++) begin
      chk1("div_busy", md_busy, 1'b1);
      step();
    end
    chk1("mflo_go_busy", md_busy, 1'b0);
    #1; chk1("mflo_go_i0", issue0, 1'b1);
    step();
    chk32("div_stall_delta", stall_cnt, s0 + 32'd32);

    // Multiply occupancy and reset mid-busy.
    clear_inputs();
    set_d0(ClsMuldiv, 1'b0, 5'd0, 5'd1, 1'b1);
    #1; chk1("mul_isdiv", md_is_div, 1'b0);
    step();
    clear_inputs();
    chk1("mul_b1", md_busy, 1'b1); step();
    chk1("mul_b2", md_busy, 1'b1); step();
    chk1("mul_b3", md_busy, 1'b0);
    set_d0(ClsMuldiv, 1'b0, 5'd0, 5'd1, 1'b1); step();
    clear_inputs(); rst = 1'b1; step();
    rst = 1'b0;
    chk1("rst_mid_busy", md_busy, 1'b0);

    // Flush and ex_stall.
    set_d0(ClsMuldiv, 1'b0, 5'd0, 5'd1, 1'b1); flush = 1'b1;
    #1; chk1("flush_start", md_start, 1'b0); chk1("flush_i0", issue0, 1'b0);
    step();
    clear_inputs();
    s0 = stall_ref;
    ex_stall = 1'b1; ex0_load = 1'b1; ex0_waddr = 5'd8;
    set_d0(ClsAlu, 1'b0, 5'd0, 5'd8, 1'b1);
    step();
    chk32("exstall_cnt", stall_cnt, s0);

    // Second-pipe class restrictions.
    clear_inputs();
    set_d0(ClsPriv, 1'b0, 5'd0, 5'd1, 1'b1); set_d1(ClsAlu, 5'd2, 1'b1);
    #1; chk1("priv_i1", issue1, 1'b0); step();
    set_d0(ClsBranch, 1'b0, 5'd0, 5'd1, 1'b1);
    #1; chk1("br_i1", issue1, 1'b1); step();
    set_d1(ClsLoad, 5'd2, 1'b1);
    #1; chk1("ld_i1", issue1, 1'b0); step();

    // Randomized traffic.
    for (int n = 0; n < 600; n++) begin
      rst       = ($urandom_range(0, 199) == 0);
      flush     = ($urandom_range(0, 9) == 0);
      ex_stall  = ($urandom_range(0, 7) == 0);
      d0_valid  = ($urandom_range(0, 7) != 0);
      d1_valid  = ($urandom_range(0, 3) != 0);
      d0_rs     = 5'($urandom_range(0, 3)); d0_rt = 5'($urandom_range(0, 3));
      d1_rs     = 5'($urandom_range(0, 3)); d1_rt = 5'($urandom_range(0, 3));
      d0_rs_ren = 1'($urandom_range(0, 1)); d0_rt_ren = 1'($urandom_range(0, 1));
      d1_rs_ren = 1'($urandom_range(0, 1)); d1_rt_ren = 1'($urandom_range(0, 1));
      d0_wen    = 1'($urandom_range(0, 1)); d1_wen = 1'($urandom_range(0, 1));
      d0_waddr  = 5'($urandom_range(0, 3)); d1_waddr = 5'($urandom_range(0, 3));
      ex0_load  = 1'($urandom_range(0, 1)); ex0_waddr = 5'($urandom_range(0, 3));
      d0_is_div = 1'($urandom_range(0, 1));
      c = int'($urandom_range(0, 11));
      d0_class  = insn_class_e'(3'((c > 6) ? 0 : c));
      c = int'($urandom_range(0, 9));
      d1_class  = insn_class_e'(3'((c > 6) ? 0 : c));
      step();
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/issue_ctrl.md
# issue_ctrl

Dual-issue scheduler for the decode/issue stage. Each cycle it decides whether the decoded pair issues as two instructions, one, or none. Rules:
- Only hazards the forwarding network cannot cover block issue: load-use and HI/LO multiply/divide occupancy.
- The first pipe takes every instruction class; the second pipe takes ALU only.
- The block owns the multiply/divide busy timer and a hazard-stall performance counter.

## Interface
Parameters:
- DIV_CYCLES, 32, cycles divider occupies HI/LO after start (≥1)
- MUL_CYCLES, 2, cycles multiplier occupies HI/LO after start (≥1, ≤DIV_CYCLES)

Ports:
- clk  in  1  clock; single clock domain
- rst  in  1  reset, synchronous, active-high
- flush  in  1  exception/ERET kill of decode pair
- ex_stall  in  1  downstream hold; nothing issues this cycle
- d0_valid / d1_valid  in  1  slot 0 (older) / slot 1 valid
- dN_rs, dN_rt  in  5  source regs (N = 0, 1)
- dN_rs_ren, dN_rt_ren  in  1  source read enables
- dN_wen  in  1  writes GPR
- dN_waddr  in  5  destination GPR
- dN_class  in  3  ALU=0, LOAD=1, STORE=2, BRANCH=3, MULDIV=4, HILO_RD=5, PRIV=6
- d0_is_div  in  1  slot-0 MULDIV is a divide
- ex0_load  in  1  load in first-pipe EX stage
- ex0_waddr  in  5  its destination
- issue0, issue1  out  1  slot issues this cycle
- md_start  out  1  start multiply/divide unit
- md_is_div  out  1  qualifies md_start
- md_busy  out  1  HI/LO occupied
- stall_cnt  out  32  hazard-stall cycle counter

## Operation
Definitions:
- loaduse(N) = ex0_load & ex0_waddr≠0 & ((dN_rs_ren & dN_rs==ex0_waddr) | (dN_rt_ren & dN_rt==ex0_waddr)).
- raw10 = d0_wen & d0_waddr≠0 & d1 reads d0_waddr (via rs_ren/rt_ren).

Issue rules:
- issue0 = d0_valid & ~flush & ~ex_stall & ~loaduse(0) & ~(md_busy & d0_class∈{MULDIV, HILO_RD}).
- issue1 = issue0 & d1_valid & d1_class==ALU & ~raw10 & ~loaduse(1) & d0_class≠PRIV.
- WAW between slots is allowed; the younger write wins through forwarding priority.
- A branch in slot 0 may pair with its delay slot in slot 1.
- When d1_valid & issue0 & ~issue1, the frontend re-presents d1 as d0 next cycle. The block keeps no instruction state.

Multiply/divide:
- md_start = issue0 & d0_class==MULDIV.
- md_is_div = d0_is_div & md_start; it is 0 whenever md_start is 0.

Multiply/divide FSM (sub-module md_busy_timer):
- IDLE: md_busy=0. On md_start, load cnt = (div ? DIV_CYCLES : MUL_CYCLES) − 1 and go to BUSY.
- BUSY: md_busy=1; cnt decrements each cycle, including under ex_stall and flush. When cnt==0, go to IDLE next cycle.
- md_start cannot occur in BUSY; the issue rule blocks it.

stall_cnt:
- Increments when d0_valid & ~flush & ~ex_stall & ~issue0.
- Saturates at 0xFFFFFFFF.

## Timing
- issue0, issue1, md_start and md_is_div are combinational from inputs and registered state. There is no added latency.
- md_start in cycle t → md_busy high t+1 … t+N, with N = DIV_CYCLES or MUL_CYCLES. The earliest HILO_RD or MULDIV issue is t+N+1.
- Load-use costs exactly one cycle. The next cycle the load is in MEM and forwarding covers it.
- Reset values: FSM IDLE, cnt 0, md_busy 0, stall_cnt 0. With all inputs idle: issue0=issue1=md_start=md_is_div=0.
- rst mid-BUSY: IDLE and md_busy=0 the next cycle. The in-flight result is abandoned.
- flush in the same cycle as an eligible MULDIV: flush wins, no md_start.
- flush does not abort an earlier-started operation; the owning instruction is older and already committed.
- ex_stall with a hazard present: not counted in stall_cnt.
- cnt width is $clog2(DIV_CYCLES+1).

## Structure
- Package gemini_issue_pkg holds:
  - class encodings (ALU…PRIV) as a 3-bit typedef;
  - DIV_CYCLES/MUL_CYCLES defaults.
- Sub-module md_busy_timer holds the FSM and down-counter. Ports: clk, rst, start, is_div, busy.
- issue_ctrl holds the hazard compare logic and stall_cnt.

## Test plan
- Pair-issue checks:
  - d0 ALU writes r5; d1 ALU reads r5 → issue0=1, issue1=0.
  - Same pair with d1 reading r6 → both issue.
  - Pair with r0 as the d0 destination and the d1 source → both issue.
- Load-use: ex0_load with ex0_waddr=r8; d0 reads r8 → issue0=0 and stall_cnt +1. Next cycle with ex0_load=0 → issue0=1.
- Divide occupancy, DIV_CYCLES=32:
  - DIV issued at t → md_busy high t+1..t+32.
  - MFLO in d0 during t+1..t+32 → issue0=0.
  - MFLO issues at t+33; stall_cnt rises by 32.
- MULT with MUL_CYCLES=2 → md_is_div=0 and md_busy high exactly 2 cycles. rst asserted in the first busy cycle → md_busy=0 the next cycle.
- flush with d0 MULDIV → md_start=0 and issue0=0. ex_stall with a load-use hazard → issue0=0 and stall_cnt unchanged.
- d0 PRIV with d1 ALU → issue1=0. d0 BRANCH with d1 ALU, no RAW → both issue. d1 LOAD → issue1=0.
